// File: rtl/cache_controller.sv
// 4-way set-associative write-back/write-allocate data cache controller with true-LRU
// replacement, 4-beat line refill from memory and dirty-victim handoff to an MSHR.
module cache_controller #(
    parameter int ADR_WIDTH     = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int WORD_OFFSET   = 2,
    parameter int DATAMEM_WIDTH = 128,
    parameter int INDEX_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_cpu2cc,
    input  logic [ADR_WIDTH-1:0]     adr_cpu2cc,
    input  logic [DATA_WIDTH-1:0]    dat_cpu2cc,
    input  logic                     rdwr_cpu2cc,
    input  logic                     lb_cpu2cc,
    input  logic                     lbu_cpu2cc,
    output logic                     ack_cc2cpu,
    output logic [DATA_WIDTH-1:0]    dat_cc2cpu,
    output logic                     req_cc2mem,
    output logic [ADR_WIDTH-1:0]     adr_cc2mem,
    input  logic                     ack_mem2cc,
    input  logic [DATA_WIDTH-1:0]    dat_mem2cc,
    output logic [DATA_WIDTH-1:0]    dat_mem2mshr,
    output logic [WORD_OFFSET-1:0]   word_mem2mshr,
    output logic [DATAMEM_WIDTH-1:0] dat_cc2mshr
);
    localparam int WAYS      = 4;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int BYTE_BITS = 2;
    localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET - BYTE_BITS;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESP    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] load_extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [BYTE_BITS-1:0]  byte_sel,
        input logic                  is_lb,
        input logic                  is_lbu
    );
        logic [7:0] b;
        b = word[int'(byte_sel)*8 +: 8];
        if (is_lb) begin
            load_extract = {{(DATA_WIDTH-8){b[7]}}, b};
        end else if (is_lbu) begin
            load_extract = {{(DATA_WIDTH-8){1'b0}}, b};
        end else begin
            load_extract = word;
        end
    endfunction

    function automatic logic [DATAMEM_WIDTH-1:0] line_put(
        input logic [DATAMEM_WIDTH-1:0] line,
        input logic [WORD_OFFSET-1:0]   sel,
        input logic [DATA_WIDTH-1:0]    word
    );
        line_put = line;
        line_put[int'(sel)*DATA_WIDTH +: DATA_WIDTH] = word;
    endfunction

    logic [DATAMEM_WIDTH-1:0] data_mem  [WAYS][SETS];
    logic [TAG_WIDTH-1:0]     tag_mem   [WAYS][SETS];
    logic                     valid_mem [WAYS][SETS];
    logic                     dirty_mem [WAYS][SETS];
    logic [1:0]               lru_mem   [WAYS][SETS];

    state_t                   state_r, state_nxt_s;
    logic [INDEX_WIDTH-1:0]   init_cnt_r, init_cnt_nxt_s;
    logic [ADR_WIDTH-1:0]     adr_r, adr_nxt_s;
    logic [DATA_WIDTH-1:0]    wdat_r, wdat_nxt_s;
    logic                     rdwr_r, rdwr_nxt_s;
    logic                     lb_r, lb_nxt_s;
    logic                     lbu_r, lbu_nxt_s;
    logic [1:0]               way_r, way_nxt_s;
    logic [WORD_OFFSET-1:0]   word_cnt_r, word_cnt_nxt_s;
    logic [DATAMEM_WIDTH-1:0] refill_line_r, refill_line_nxt_s;
    logic                     ack_r, ack_nxt_s;
    logic [DATA_WIDTH-1:0]    rdat_r, rdat_nxt_s;
    logic                     mem_req_r, mem_req_nxt_s;
    logic [ADR_WIDTH-1:0]     mem_adr_r, mem_adr_nxt_s;
    logic [DATA_WIDTH-1:0]    mshr_dat_r, mshr_dat_nxt_s;
    logic [WORD_OFFSET-1:0]   mshr_word_r, mshr_word_nxt_s;
    logic [DATAMEM_WIDTH-1:0] victim_line_r, victim_line_nxt_s;

    logic [INDEX_WIDTH-1:0]   index_s;
    logic [TAG_WIDTH-1:0]     tag_s;
    logic [WORD_OFFSET-1:0]   word_sel_s;
    logic [WAYS-1:0]          valid_set_s, dirty_set_s, hit_vec_s;
    logic [1:0]               lru_set_s [WAYS];
    logic [1:0]               lru_new_s [WAYS];
    logic                     hit_s;
    logic [1:0]               hit_way_s, victim_way_s, best_rank_s, old_rank_s;
    logic [DATAMEM_WIDTH-1:0] acc_line_s, fill_line_s, merge_line_s;
    logic [DATA_WIDTH-1:0]    resp_word_s;
    logic                     init_we_s, fill_we_s, resp_wr_s, lru_we_s;

    assign index_s      = adr_r[INDEX_WIDTH+WORD_OFFSET+BYTE_BITS-1 : WORD_OFFSET+BYTE_BITS];
    assign tag_s        = adr_r[ADR_WIDTH-1 -: TAG_WIDTH];
    assign word_sel_s   = adr_r[WORD_OFFSET+BYTE_BITS-1 : BYTE_BITS];
    assign acc_line_s   = data_mem[way_r][index_s];
    assign resp_word_s  = acc_line_s[int'(word_sel_s)*DATA_WIDTH +: DATA_WIDTH];
    assign merge_line_s = line_put(acc_line_s, word_sel_s, wdat_r);
    assign fill_line_s  = line_put(refill_line_r, word_cnt_r, dat_mem2cc);

    assign ack_cc2cpu    = ack_r;
    assign dat_cc2cpu    = rdat_r;
    assign req_cc2mem    = mem_req_r;
    assign adr_cc2mem    = mem_adr_r;
    assign dat_mem2mshr  = mshr_dat_r;
    assign word_mem2mshr = mshr_word_r;
    assign dat_cc2mshr   = victim_line_r;

    // Tag match, victim choice (lowest invalid way, else highest rank) and LRU re-ranking
    always_comb begin
        hit_way_s    = 2'd0;
        victim_way_s = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            valid_set_s[w] = valid_mem[w][index_s];
            dirty_set_s[w] = dirty_mem[w][index_s];
            lru_set_s[w]   = lru_mem[w][index_s];
            hit_vec_s[w]   = valid_mem[w][index_s] && (tag_mem[w][index_s] == tag_s);
        end
        hit_s       = |hit_vec_s;
        best_rank_s = lru_set_s[0];
        for (int w = 1; w < WAYS; w++) begin
            victim_way_s = (lru_set_s[w] > best_rank_s) ? 2'(w) : victim_way_s;
            best_rank_s  = (lru_set_s[w] > best_rank_s) ? lru_set_s[w] : best_rank_s;
        end
        for (int w = WAYS-1; w >= 0; w--) begin
            hit_way_s    = hit_vec_s[w] ? 2'(w) : hit_way_s;
            victim_way_s = valid_set_s[w] ? victim_way_s : 2'(w);
        end
        old_rank_s = lru_set_s[way_r];
        for (int w = 0; w < WAYS; w++) begin
            if (2'(w) == way_r) begin
                lru_new_s[w] = 2'd0;
            end else if (lru_set_s[w] < old_rank_s) begin
                lru_new_s[w] = lru_set_s[w] + 2'd1;
            end else begin
                lru_new_s[w] = lru_set_s[w];
            end
        end
    end

    // FSM next state, next register values and storage write enables
    always_comb begin
        state_nxt_s       = state_r;
        init_cnt_nxt_s    = init_cnt_r;
        adr_nxt_s         = adr_r;
        wdat_nxt_s        = wdat_r;
        rdwr_nxt_s        = rdwr_r;
        lb_nxt_s          = lb_r;
        lbu_nxt_s         = lbu_r;
        way_nxt_s         = way_r;
        word_cnt_nxt_s    = word_cnt_r;
        refill_line_nxt_s = refill_line_r;
        ack_nxt_s         = 1'b0;
        rdat_nxt_s        = rdat_r;
        mem_req_nxt_s     = mem_req_r;
        mem_adr_nxt_s     = mem_adr_r;
        mshr_dat_nxt_s    = mshr_dat_r;
        mshr_word_nxt_s   = mshr_word_r;
        victim_line_nxt_s = victim_line_r;
        init_we_s         = 1'b0;
        fill_we_s         = 1'b0;
        resp_wr_s         = 1'b0;
        lru_we_s          = 1'b0;
        case (state_r)
            ST_INIT: begin
                init_we_s      = 1'b1;
                init_cnt_nxt_s = init_cnt_r + INDEX_WIDTH'(1'b1);
                if (init_cnt_r == {INDEX_WIDTH{1'b1}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (req_cpu2cc) begin
                    adr_nxt_s   = adr_cpu2cc;
                    wdat_nxt_s  = dat_cpu2cc;
                    rdwr_nxt_s  = rdwr_cpu2cc;
                    lb_nxt_s    = lb_cpu2cc;
                    lbu_nxt_s   = lbu_cpu2cc;
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    way_nxt_s   = hit_way_s;
                    state_nxt_s = ST_RESP;
                end else begin
                    way_nxt_s         = victim_way_s;
                    victim_line_nxt_s = dirty_set_s[victim_way_s] ?
                                        data_mem[victim_way_s][index_s] : victim_line_r;
                    mem_req_nxt_s     = 1'b1;
                    mem_adr_nxt_s     = {tag_s, index_s, {(WORD_OFFSET+BYTE_BITS){1'b0}}};
                    word_cnt_nxt_s    = {WORD_OFFSET{1'b0}};
                    refill_line_nxt_s = {DATAMEM_WIDTH{1'b0}};
                    state_nxt_s       = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (ack_mem2cc) begin
                    refill_line_nxt_s = fill_line_s;
                    mshr_dat_nxt_s    = dat_mem2cc;
                    mshr_word_nxt_s   = word_cnt_r;
                    word_cnt_nxt_s    = word_cnt_r + WORD_OFFSET'(1'b1);
                    if (word_cnt_r == {WORD_OFFSET{1'b1}}) begin
                        fill_we_s     = 1'b1;
                        mem_req_nxt_s = 1'b0;
                        state_nxt_s   = ST_RESP;
                    end else begin
                        state_nxt_s = ST_REFILL;
                    end
                end else begin
                    state_nxt_s = ST_REFILL;
                end
            end
            ST_RESP: begin
                ack_nxt_s = 1'b1;
                lru_we_s  = 1'b1;
                if (rdwr_r) begin
                    resp_wr_s = 1'b1;
                end else begin
                    rdat_nxt_s = load_extract(resp_word_s, adr_r[BYTE_BITS-1:0], lb_r, lbu_r);
                end
                state_nxt_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (req_cpu2cc) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= {INDEX_WIDTH{1'b0}};
            adr_r         <= {ADR_WIDTH{1'b0}};
            wdat_r        <= {DATA_WIDTH{1'b0}};
            rdwr_r        <= 1'b0;
            lb_r          <= 1'b0;
            lbu_r         <= 1'b0;
            way_r         <= 2'd0;
            word_cnt_r    <= {WORD_OFFSET{1'b0}};
            refill_line_r <= {DATAMEM_WIDTH{1'b0}};
            ack_r         <= 1'b0;
            rdat_r        <= {DATA_WIDTH{1'b0}};
            mem_req_r     <= 1'b0;
            mem_adr_r     <= {ADR_WIDTH{1'b0}};
            mshr_dat_r    <= {DATA_WIDTH{1'b0}};
            mshr_word_r   <= {WORD_OFFSET{1'b0}};
            victim_line_r <= {DATAMEM_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            init_cnt_r    <= init_cnt_nxt_s;
            adr_r         <= adr_nxt_s;
            wdat_r        <= wdat_nxt_s;
            rdwr_r        <= rdwr_nxt_s;
            lb_r          <= lb_nxt_s;
            lbu_r         <= lbu_nxt_s;
            way_r         <= way_nxt_s;
            word_cnt_r    <= word_cnt_nxt_s;
            refill_line_r <= refill_line_nxt_s;
            ack_r         <= ack_nxt_s;
            rdat_r        <= rdat_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_adr_r     <= mem_adr_nxt_s;
            mshr_dat_r    <= mshr_dat_nxt_s;
            mshr_word_r   <= mshr_word_nxt_s;
            victim_line_r <= victim_line_nxt_s;
        end
    end

    // Tag/data/state arrays; INIT seeds each set's ranks with the way number so they form a permutation
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                if (init_we_s) begin
                    valid_mem[w][init_cnt_r] <= 1'b0;
                    dirty_mem[w][init_cnt_r] <= 1'b0;
                    lru_mem[w][init_cnt_r]   <= 2'(w);
                end
                if (fill_we_s && (way_r == 2'(w))) begin
                    data_mem[w][index_s]  <= fill_line_s;
                    tag_mem[w][index_s]   <= tag_s;
                    valid_mem[w][index_s] <= 1'b1;
                    dirty_mem[w][index_s] <= 1'b0;
                end
                if (resp_wr_s && (way_r == 2'(w))) begin
                    data_mem[w][index_s]  <= merge_line_s;
                    dirty_mem[w][index_s] <= 1'b1;
                end
                if (lru_we_s) begin
                    lru_mem[w][index_s] <= lru_new_s[w];
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: expected CPU read data goes into a scoreboard queue,
// a monitor compares it on every ack; a memory model serves refills and checks MSHR outputs.
module tb_cache_controller;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_cpu2cc = 1'b0;
    logic [31:0]  adr_cpu2cc = 32'h0;
    logic [31:0]  dat_cpu2cc = 32'h0;
    logic         rdwr_cpu2cc = 1'b0;
    logic         lb_cpu2cc = 1'b0;
    logic         lbu_cpu2cc = 1'b0;
    logic         ack_cc2cpu;
    logic [31:0]  dat_cc2cpu;
    logic         req_cc2mem;
    logic [31:0]  adr_cc2mem;
    logic         ack_mem2cc = 1'b0;
    logic [31:0]  dat_mem2cc = 32'h0;
    logic [31:0]  dat_mem2mshr;
    logic [1:0]   word_mem2mshr;
    logic [127:0] dat_cc2mshr;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .req_cpu2cc(req_cpu2cc), .adr_cpu2cc(adr_cpu2cc), .dat_cpu2cc(dat_cpu2cc),
        .rdwr_cpu2cc(rdwr_cpu2cc), .lb_cpu2cc(lb_cpu2cc), .lbu_cpu2cc(lbu_cpu2cc),
        .ack_cc2cpu(ack_cc2cpu), .dat_cc2cpu(dat_cc2cpu),
        .req_cc2mem(req_cc2mem), .adr_cc2mem(adr_cc2mem),
        .ack_mem2cc(ack_mem2cc), .dat_mem2cc(dat_mem2cc),
        .dat_mem2mshr(dat_mem2mshr), .word_mem2mshr(word_mem2mshr),
        .dat_cc2mshr(dat_cc2mshr)
    );

    int          checks = 0;
    int          errors = 0;
    int          ack_count = 0;
    int          refill_count = 0;
    logic [31:0] last_mem_adr = 32'h0;
    logic [31:0] mem_pat = 32'h0;
    logic [31:0] mem_step = 32'h0;
    logic [31:0] exp_q[$];
    bit          chk_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every CPU ack consumes one expected entry
    always @(negedge clk) begin
        if (!rst && ack_cc2cpu) begin
            ack_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with data %h expected no ack", dat_cc2cpu);
            end else begin
                logic [31:0] e;
                bit          c;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                if (c) check("cpu_rdata", 128'(dat_cc2cpu), 128'(e));
            end
        end
    end

    // Memory model: 4 beats of mem_pat + k*mem_step with one stall before beat 2
    initial begin
        logic [31:0] wd;
        forever begin
            @(negedge clk);
            if (req_cc2mem && !rst) begin
                refill_count++;
                last_mem_adr = adr_cc2mem;
                for (int k = 0; k < 4; k++) begin
                    if (k == 2) begin
                        ack_mem2cc = 1'b0;
                        @(negedge clk);
                    end
                    wd = mem_pat + mem_step * 32'(k);
                    ack_mem2cc = 1'b1;
                    dat_mem2cc = wd;
                    @(negedge clk);
                    check("mshr_dat", 128'(dat_mem2mshr), 128'(wd));
                    check("mshr_word", 128'(word_mem2mshr), 128'(k));
                    check("mem_req_level", 128'(req_cc2mem), (k < 3) ? 128'd1 : 128'd0);
                end
                ack_mem2cc = 1'b0;
                dat_mem2cc = 32'h0;
            end
        end
    end

    task automatic cpu_access(input string name, input logic [31:0] adr, input logic [31:0] wdat,
                              input logic wr, input logic lb, input logic lbu,
                              input logic [31:0] exp, input bit exp_hit, input int hold);
        int n;
        int rc0;
        int ac0;
        exp_q.push_back(exp);
        chk_q.push_back(!wr);
        rc0 = refill_count;
        ac0 = ack_count;
        adr_cpu2cc  = adr;
        dat_cpu2cc  = wdat;
        rdwr_cpu2cc = wr;
        lb_cpu2cc   = lb;
        lbu_cpu2cc  = lbu;
        req_cpu2cc  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_cc2cpu && n < 200);
        if (!ack_cc2cpu) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack after %0d cycles expected ack", name, n);
        end else if (exp_hit) begin
            check({name, "_hit_latency"}, 128'(n), 128'd3);
            check({name, "_no_refill"}, 128'(refill_count), 128'(rc0));
        end else begin
            check({name, "_refill_count"}, 128'(refill_count), 128'(rc0 + 1));
            check({name, "_refill_adr"}, 128'(last_mem_adr), 128'({adr[31:4], 4'h0}));
        end
        repeat (hold) @(negedge clk);
        req_cpu2cc = 1'b0;
        lb_cpu2cc  = 1'b0;
        lbu_cpu2cc = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_one_ack"}, 128'(ack_count), 128'(ac0 + 1));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ack"}, 128'(ack_cc2cpu), 128'd0);
        check({name, "_cpu_dat"}, 128'(dat_cc2cpu), 128'd0);
        check({name, "_mem_req"}, 128'(req_cc2mem), 128'd0);
        check({name, "_mem_adr"}, 128'(adr_cc2mem), 128'd0);
        check({name, "_mshr_dat"}, 128'(dat_mem2mshr), 128'd0);
        check({name, "_mshr_word"}, 128'(word_mem2mshr), 128'd0);
        check({name, "_victim"}, dat_cc2mshr, 128'd0);
    endtask

    initial begin
        repeat (42) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Requests during INIT are ignored
        repeat (20) @(negedge clk);
        adr_cpu2cc = 32'hFF07BD08;
        lb_cpu2cc  = 1'b1;
        req_cpu2cc = 1'b1;
        repeat (100) @(negedge clk);
        check("init_no_ack", 128'(ack_count), 128'd0);
        check("init_no_refill", 128'(refill_count), 128'd0);
        req_cpu2cc = 1'b0;
        lb_cpu2cc  = 1'b0;
        repeat (392) @(negedge clk);

        // 1: first miss, signed byte of all-ones line
        mem_pat = 32'hFFFFFFFF; mem_step = 32'h0;
        cpu_access("t1_lb_miss", 32'hFF07BD08, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 0);

        // Memory strobes outside a refill are ignored
        ack_mem2cc = 1'b1;
        dat_mem2cc = 32'h12345678;
        repeat (2) @(negedge clk);
        ack_mem2cc = 1'b0;
        dat_mem2cc = 32'h0;
        check("stray_ack_dat", 128'(dat_mem2mshr), 128'hFFFFFFFF);
        check("stray_ack_word", 128'(word_mem2mshr), 128'd3);

        // 2: fill remaining ways of set 0xD0
        mem_step = 32'h00000111;
        mem_pat = 32'h10000000;
        cpu_access("t2_miss_b", 32'hA5552D08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10000222, 1'b0, 0);
        mem_pat = 32'h20000000;
        cpu_access("t2_miss_c", 32'hD500AD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20000222, 1'b0, 0);
        mem_pat = 32'h30000000;
        cpu_access("t2_miss_d", 32'hFFFFFD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h30000222, 1'b0, 0);

        // 3: hits
        cpu_access("t3_hit_a", 32'hFF07BD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 0);
        cpu_access("t3_wr_d", 32'hFFFFFD08, 32'hAA8AAAA4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        cpu_access("t3_rd_d", 32'hFFFFFD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'hAA8AAAA4, 1'b1, 0);
        cpu_access("t3_hit_c", 32'hD500AD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20000222, 1'b1, 0);

        // 4: write miss evicts clean LRU way1
        mem_pat = 32'h40000000;
        cpu_access("t4_wr_miss_e", 32'h5F57ED08, 32'hAAAAAAAA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
        check("t4_clean_victim", dat_cc2mshr, 128'd0);
        cpu_access("t4_rd_e", 32'h5F57ED08, 32'h0, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b1, 0);
        cpu_access("t4_rd_e_w1", 32'h5F57ED04, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40000111, 1'b1, 0);

        // 5: dirty way3 evicted to the MSHR
        cpu_access("t5_wr_a", 32'hFF07BD08, 32'hDDDDDDDD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
        mem_pat = 32'h50000000;
        cpu_access("t5_miss_f", 32'h12345D08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h50000222, 1'b0, 0);
        check("t5_victim_word2", 128'(dat_cc2mshr[95:64]), 128'hAA8AAAA4);
        check("t5_victim_line", dat_cc2mshr,
              {32'h30000333, 32'hAA8AAAA4, 32'h30000111, 32'h30000000});
        cpu_access("t5_hit_c", 32'hD500AD08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20000222, 1'b1, 0);
        cpu_access("t5_hit_e", 32'h5F57ED04, 32'h0, 1'b0, 1'b0, 1'b0, 32'h40000111, 1'b1, 0);

        // 6: byte loads with held requests
        cpu_access("t6_lb", 32'hFF07BD09, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFDD, 1'b1, 3);
        cpu_access("t6_lbu", 32'hFF07BD09, 32'h0, 1'b0, 1'b0, 1'b1, 32'h000000DD, 1'b1, 3);
        cpu_access("t6_lb_prio", 32'hFF07BD09, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFDD, 1'b1, 0);
        cpu_access("t6_lb_pos", 32'h12345D08, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00000022, 1'b1, 0);
        cpu_access("t6_lb_b3", 32'h12345D0B, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00000050, 1'b1, 0);

        // Clean eviction of way2 leaves the MSHR line untouched
        mem_pat = 32'h60000000;
        cpu_access("t7_miss_b", 32'hA5552D08, 32'h0, 1'b0, 1'b0, 1'b0, 32'h60000222, 1'b0, 0);
        check("t7_victim_held", dat_cc2mshr,
              {32'h30000333, 32'hAA8AAAA4, 32'h30000111, 32'h30000000});

        // Reset clears every output
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst_again");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
